// File: rtl/axi_rd_pkg.sv
// Shared types and defaults for the AXI4 single-ID read initiator.
package axi_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_AR   = 2'b01,
      ST_R    = 2'b11,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1024;

endpackage

// File: rtl/axi_rd_if.sv
// AXI4 read address/data channels (single ID, INCR bursts).
interface axi_rd_if #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32
);
   logic                  axi_arvalid;
   logic                  axi_arready;
   logic [ADDR_WIDTH-1:0] axi_araddr;
   logic [7:0]            axi_arlen;
   logic                  axi_rvalid;
   logic                  axi_rready;
   logic [DATA_WIDTH-1:0] axi_rdata;
   logic                  axi_rlast;

   modport master (
      output axi_arvalid, axi_araddr, axi_arlen, axi_rready,
      input  axi_arready, axi_rvalid, axi_rdata, axi_rlast
   );

   modport slave (
      input  axi_arvalid, axi_araddr, axi_arlen, axi_rready,
      output axi_arready, axi_rvalid, axi_rdata, axi_rlast
   );
endinterface

// File: rtl/axi_rd_watchdog.sv
// Idle-cycle counter for the AR/R phases; expires at TIMEOUT_CYCLES.
module axi_rd_watchdog #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic hs,
   output logic expired
);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!active || hs) begin
         cnt <= '0;
      end else if (cnt != TIMEOUT_CYCLES) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign expired = active && (cnt == TIMEOUT_CYCLES);

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 read initiator: one INCR burst per trigger, length-checked.
// Optional R/AR watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi_rd_master
   import axi_rd_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 26,
   parameter int          DATA_WIDTH     = 32,
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_end,
   input  logic                  rd_trig,
   input  logic [7:0]            rd_len,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  rd_done,
   output logic                  rd_err,
   axi_rd_if.master              axi
);

   state_t                state_q, state_d;
   logic [7:0]            beat_q, beat_d;
   logic                  over_q, over_d;
   logic                  err_q, err_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic                  ar_hs, beat, expired;

   assign ar_hs = arvalid_q & axi.axi_arready;
   assign beat  = axi.axi_rvalid & rready_q;

`ifdef AXI_RD_TIMEOUT_EN
   axi_rd_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .active ((state_q == ST_AR) || (state_q == ST_R)),
      .hs     (ar_hs | beat),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      over_d    = over_q;
      err_d     = err_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rd_trig && init_end && (rd_len != 8'd0)) begin
               state_d   = ST_AR;
               araddr_d  = rd_addr;
               arlen_d   = rd_len - 8'd1;
               beat_d    = rd_len - 8'd1;
               arvalid_d = 1'b1;
               over_d    = 1'b0;
               err_d     = 1'b0;
            end
         end
         ST_AR: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_R;
            end else if (expired) begin
               arvalid_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_R: begin
            if (beat) begin
               // beat_q == 0 means the expected final beat is being taken now
               if (beat_q != 8'd0) beat_d = beat_q - 8'd1;
               else                over_d = 1'b1;
               if (axi.axi_rlast) begin
                  rready_d = 1'b0;
                  err_d    = (beat_q != 8'd0) | over_q;
                  state_d  = ST_DONE;
               end
            end else if (expired) begin
               rready_d = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         over_q    <= 1'b0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         over_q    <= over_d;
         err_q     <= err_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
      end
   end

   assign axi.axi_arvalid = arvalid_q;
   assign axi.axi_araddr  = araddr_q;
   assign axi.axi_arlen   = arlen_q;
   assign axi.axi_rready  = rready_q;

   assign rd_ready      = (state_q == ST_IDLE);
   assign rd_done       = (state_q == ST_DONE);
   assign rd_err        = rd_done & err_q;
   assign rd_data       = axi.axi_rdata;
   assign rd_data_valid = beat & ~over_q;

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed + randomized bench for axi_rd_master with a burst-level model.
module tb_axi_rd_master;

`ifdef AXI_RD_TIMEOUT_EN
   localparam logic [15:0] TOC = 16'd16;
`else
   localparam logic [15:0] TOC = 16'd1024;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_end = 1'b0;
   logic        rd_trig = 1'b0;
   logic [7:0]  rd_len = 8'd0;
   logic [25:0] rd_addr = '0;
   logic        rd_ready, rd_data_valid, rd_done, rd_err;
   logic [31:0] rd_data;

   int errors = 0;
   int checks = 0;
   logic [31:0] got[$];

   axi_rd_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) axi ();

   axi_rd_master #(
      .ADDR_WIDTH(26), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TOC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_end(init_end),
      .rd_trig(rd_trig), .rd_len(rd_len), .rd_addr(rd_addr),
      .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .rd_done(rd_done),
      .rd_err(rd_err), .axi(axi.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rd_data_valid) got.push_back(rd_data);

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input int len, input int nbeats,
                            input logic [25:0] addr, input int ar_dly,
                            input bit gap, input bit seq);
      logic [31:0] exp_q[$];
      logic [31:0] d;
      got.delete();
      rd_trig = 1'b1;
      rd_len  = 8'(len);
      rd_addr = addr;
      cyc();
      rd_trig = 1'b0;
      chk("arvalid_set", axi.axi_arvalid, 1);
      chk("araddr", axi.axi_araddr, addr);
      chk("arlen", axi.axi_arlen, len - 1);
      for (int i = 0; i < ar_dly; i++) begin
         rd_addr = 26'($urandom);
         rd_len  = 8'($urandom);
         cyc();
         chk("ar_hold_valid", axi.axi_arvalid, 1);
         chk("ar_hold_addr", axi.axi_araddr, addr);
         chk("ar_hold_len", axi.axi_arlen, len - 1);
      end
      axi.axi_arready = 1'b1;
      cyc();
      axi.axi_arready = 1'b0;
      chk("arvalid_clr", axi.axi_arvalid, 0);
      chk("rready_set", axi.axi_rready, 1);
      for (int i = 0; i < nbeats; i++) begin
         if (gap) begin
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast  = 1'b0;
            cyc();
         end
         d = seq ? 32'(i) : $urandom;
         if (i < len) exp_q.push_back(d);
         axi.axi_rvalid = 1'b1;
         axi.axi_rdata  = d;
         axi.axi_rlast  = (i == nbeats - 1);
         cyc();
      end
      axi.axi_rvalid = 1'b0;
      axi.axi_rlast  = 1'b0;
      chk("done_pulse", rd_done, 1);
      chk("done_err", rd_err, (nbeats != len));
      chk("rready_clr", axi.axi_rready, 0);
      chk("done_not_ready", rd_ready, 0);
      cyc();
      chk("ready_after", rd_ready, 1);
      chk("done_single", rd_done, 0);
      chk("err_idle", rd_err, 0);
      chk("beat_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk("beat_data", got[i], exp_q[i]);
   endtask

   initial begin
      int len, nb, n;
      axi.axi_arready = 1'b0;
      axi.axi_rvalid  = 1'b0;
      axi.axi_rdata   = '0;
      axi.axi_rlast   = 1'b0;
      #12;
      chk("rst_ready", rd_ready, 1);
      chk("rst_arvalid", axi.axi_arvalid, 0);
      chk("rst_rready", axi.axi_rready, 0);
      chk("rst_araddr", axi.axi_araddr, 0);
      chk("rst_arlen", axi.axi_arlen, 0);
      chk("rst_done", rd_done, 0);
      chk("rst_err", rd_err, 0);
      rst_n = 1'b1;
      cyc();

      rd_trig = 1'b1;
      rd_len  = 8'd4;
      cyc();
      rd_trig = 1'b0;
      chk("noinit_ready", rd_ready, 1);
      chk("noinit_arvalid", axi.axi_arvalid, 0);
      init_end = 1'b1;

      rd_trig = 1'b1;
      rd_len  = 8'd0;
      cyc();
      rd_trig = 1'b0;
      chk("len0_ready", rd_ready, 1);
      chk("len0_arvalid", axi.axi_arvalid, 0);
      cyc();
      chk("len0_done", rd_done, 0);

      run_burst(8, 8, 26'h100, 0, 1'b0, 1'b1);
      run_burst(8, 8, 26'h2040, 5, 1'b1, 1'b0);
      run_burst(4, 2, 26'h300, 1, 1'b0, 1'b0);
      run_burst(4, 6, 26'h400, 0, 1'b0, 1'b0);
      run_burst(1, 1, 26'h5, 0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         len = $urandom_range(1, 20);
         case ($urandom_range(0, 2))
            0: nb = len;
            1: nb = $urandom_range(1, len);
            default: nb = len + $urandom_range(1, 3);
         endcase
         run_burst(len, nb, 26'($urandom), $urandom_range(0, 3),
                   1'($urandom), 1'b0);
      end

      rd_trig = 1'b1;
      rd_len  = 8'd8;
      rd_addr = 26'h777;
      cyc();
      rd_trig = 1'b0;
      axi.axi_arready = 1'b1;
      cyc();
      axi.axi_arready = 1'b0;
      axi.axi_rvalid  = 1'b1;
      axi.axi_rdata   = 32'hdead;
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", rd_ready, 1);
      chk("mid_rst_arvalid", axi.axi_arvalid, 0);
      chk("mid_rst_rready", axi.axi_rready, 0);
      chk("mid_rst_araddr", axi.axi_araddr, 0);
      chk("mid_rst_arlen", axi.axi_arlen, 0);
      chk("mid_rst_valid", rd_data_valid, 0);
      chk("mid_rst_done", rd_done, 0);
      chk("mid_rst_err", rd_err, 0);
      axi.axi_rvalid = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc();
      run_burst(3, 3, 26'h88, 2, 1'b1, 1'b0);

`ifdef AXI_RD_TIMEOUT_EN
      rd_trig = 1'b1;
      rd_len  = 8'd4;
      cyc();
      rd_trig = 1'b0;
      n = 0;
      while (!rd_done && n < 100) begin
         cyc();
         n++;
      end
      chk("to_done", rd_done, 1);
      chk("to_err", rd_err, 1);
      chk("to_arvalid", axi.axi_arvalid, 0);
      chk("to_cycles", n, TOC + 1);
      cyc();
      chk("to_ready", rd_ready, 1);
`else
      n = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
